// File: rtl/network_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_scheduler_pkg
// Description : Shared constants and types for the neuron scheduler: FSM
//               state encoding, layer-select codes and default dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package network_scheduler_pkg;

  localparam int c_default_fp_width   = 8;
  localparam int c_default_hl_neurons = 10;
  localparam int c_default_ol_neurons = 5;
  localparam int c_idx_width          = 4;

  localparam logic c_layer_hidden = 1'b0;
  localparam logic c_layer_output = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HL_START = 3'd1,
    ST_HL_WAIT  = 3'd2,
    ST_OL_START = 3'd3,
    ST_OL_WAIT  = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // True while the scheduler is working on the output layer.
  function automatic logic is_output_layer(input state_t s);
    return (s == ST_OL_START) || (s == ST_OL_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/network_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : network_scheduler_if
// Description : Request, engine handshake and result bus of the scheduler.
//               slave = scheduler side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface network_scheduler_if
  import network_scheduler_pkg::*;
#(
  parameter int FP_WIDTH   = c_default_fp_width,
  parameter int HL_NEURONS = c_default_hl_neurons,
  parameter int OL_NEURONS = c_default_ol_neurons
);
  logic                           VALID_IN;
  logic                           CLR_FLAGS;
  logic                           NEURON_START;
  logic                           NEURON_LAYER;
  logic [c_idx_width-1:0]         NEURON_IDX;
  logic                           NEURON_DONE;
  logic [FP_WIDTH-1:0]            NEURON_RESULT;
  logic                           NEURON_OVF;
  logic [HL_NEURONS*FP_WIDTH-1:0] HL_VALUES;
  logic [OL_NEURONS*FP_WIDTH-1:0] VALUES_OUT;
  logic                           VALID_OUT;
  logic                           BUSY;
  logic                           OVERFLOW;
  logic                           TIMEOUT_ERR;
  logic                           DROPPED;

  modport slave (
    input  VALID_IN, CLR_FLAGS, NEURON_DONE, NEURON_RESULT, NEURON_OVF,
    output NEURON_START, NEURON_LAYER, NEURON_IDX, HL_VALUES, VALUES_OUT,
           VALID_OUT, BUSY, OVERFLOW, TIMEOUT_ERR, DROPPED
  );

  modport master (
    output VALID_IN, CLR_FLAGS, NEURON_DONE, NEURON_RESULT, NEURON_OVF,
    input  NEURON_START, NEURON_LAYER, NEURON_IDX, HL_VALUES, VALUES_OUT,
           VALID_OUT, BUSY, OVERFLOW, TIMEOUT_ERR, DROPPED
  );
endinterface
`default_nettype wire

// File: rtl/network_scheduler_watchdog_counter.sv
`default_nettype none
// ============================================================================
// Module      : watchdog_counter
// Description : Counts enabled cycles since the last clear. o_expired flags
//               the enabled cycle in which the count reaches i_limit.
// Revision    : 1.0 - initial release
// ============================================================================
module watchdog_counter
  import network_scheduler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_count_next;

  // One extra bit so the limit compare cannot wrap at the counter maximum.
  assign w_count_next = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign o_expired    = i_enable && (w_count_next >= {1'b0, i_limit});

  // Cycle counter: cleared by reset or i_clear, saturates at all-ones.
  always_ff @(posedge CLK) begin
    if (!RSTN || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !(&r_count)) begin
      r_count <= w_count_next[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/network_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : network_scheduler
// Description : Sequences one shared neuron engine through every hidden and
//               output neuron of an inference, buffers the results, guards
//               each engine wait with a watchdog and keeps sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module network_scheduler
  import network_scheduler_pkg::*;
#(
  parameter int FP_WIDTH       = c_default_fp_width,
  parameter int HL_NEURONS     = c_default_hl_neurons,
  parameter int OL_NEURONS     = c_default_ol_neurons,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RSTN,
  network_scheduler_if.slave  bus
);

  localparam int c_wd_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_wd_width-1:0]  c_wd_limit = c_wd_width'(TIMEOUT_CYCLES);
  localparam logic [c_idx_width-1:0] c_hl_last  = c_idx_width'(HL_NEURONS - 1);
  localparam logic [c_idx_width-1:0] c_ol_last  = c_idx_width'(OL_NEURONS - 1);
  localparam logic [c_idx_width-1:0] c_idx_one  = c_idx_width'(1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [c_idx_width-1:0]         r_idx;
  logic [HL_NEURONS*FP_WIDTH-1:0] r_hl_values;
  logic [OL_NEURONS*FP_WIDTH-1:0] r_ol_values;
  logic                           r_valid_out;
  logic                           r_overflow;
  logic                           r_timeout_err;
  logic                           r_dropped;

  logic w_neuron_start;
  logic w_accept;
  logic w_drop;
  logic w_hl_write;
  logic w_ol_write;
  logic w_timeout;
  logic w_wd_enable;
  logic w_wd_clear;
  logic w_wd_expired;

  watchdog_counter #(
    .WIDTH (c_wd_width)
  ) u_watchdog (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .i_enable  (w_wd_enable),
    .i_clear   (w_wd_clear),
    .i_limit   (c_wd_limit),
    .o_expired (w_wd_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode. The VALID_OUT cycle is the tail of the
  // finish phase, so a request landing there is dropped rather than accepted.
  // DONE is checked before the watchdog so a coincident DONE wins.
  always_comb begin
    w_state_next   = r_state;
    w_neuron_start = 1'b0;
    w_accept       = 1'b0;
    w_drop         = 1'b0;
    w_hl_write     = 1'b0;
    w_ol_write     = 1'b0;
    w_timeout      = 1'b0;
    w_wd_enable    = 1'b0;
    w_wd_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.VALID_IN) begin
          if (r_valid_out) begin
            w_drop = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = ST_HL_START;
          end
        end
      end
      ST_HL_START: begin
        w_neuron_start = 1'b1;
        w_wd_clear     = 1'b1;
        w_state_next   = ST_HL_WAIT;
      end
      ST_HL_WAIT: begin
        w_wd_enable = 1'b1;
        if (bus.NEURON_DONE) begin
          w_hl_write   = 1'b1;
          w_state_next = (r_idx == c_hl_last) ? ST_OL_START : ST_HL_START;
        end else if (w_wd_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_OL_START: begin
        w_neuron_start = 1'b1;
        w_wd_clear     = 1'b1;
        w_state_next   = ST_OL_WAIT;
      end
      ST_OL_WAIT: begin
        w_wd_enable = 1'b1;
        if (bus.NEURON_DONE) begin
          w_ol_write   = 1'b1;
          w_state_next = (r_idx == c_ol_last) ? ST_FINISH : ST_OL_START;
        end else if (w_wd_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (bus.VALID_IN && (r_state != ST_IDLE)) begin
      w_drop = 1'b1;
    end
  end

  // Neuron index: restarts per request and per layer, held while waiting.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_idx <= '0;
    end else if (w_accept || w_timeout) begin
      r_idx <= '0;
    end else if (w_hl_write) begin
      r_idx <= (r_idx == c_hl_last) ? '0 : r_idx + c_idx_one;
    end else if (w_ol_write) begin
      r_idx <= (r_idx == c_ol_last) ? '0 : r_idx + c_idx_one;
    end
  end

  // Result buffers: only the addressed neuron slot is written on DONE.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_hl_values <= '0;
      r_ol_values <= '0;
    end else begin
      for (int i = 0; i < HL_NEURONS; i++) begin
        if (w_hl_write && (r_idx == c_idx_width'(i))) begin
          r_hl_values[i*FP_WIDTH +: FP_WIDTH] <= bus.NEURON_RESULT;
        end
      end
      for (int i = 0; i < OL_NEURONS; i++) begin
        if (w_ol_write && (r_idx == c_idx_width'(i))) begin
          r_ol_values[i*FP_WIDTH +: FP_WIDTH] <= bus.NEURON_RESULT;
        end
      end
    end
  end

  // Completion pulse and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_valid_out   <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_valid_out   <= (r_state == ST_FINISH);
      r_overflow    <= ((w_hl_write || w_ol_write) && bus.NEURON_OVF) ||
                       (r_overflow && !bus.CLR_FLAGS);
      r_timeout_err <= w_timeout || (r_timeout_err && !bus.CLR_FLAGS);
      r_dropped     <= w_drop || (r_dropped && !bus.CLR_FLAGS);
    end
  end

  assign bus.NEURON_START = w_neuron_start;
  assign bus.NEURON_LAYER = is_output_layer(r_state) ? c_layer_output : c_layer_hidden;
  assign bus.NEURON_IDX   = r_idx;
  assign bus.HL_VALUES    = r_hl_values;
  assign bus.VALUES_OUT   = r_ol_values;
  assign bus.VALID_OUT    = r_valid_out;
  assign bus.BUSY         = (r_state != ST_IDLE);
  assign bus.OVERFLOW     = r_overflow;
  assign bus.TIMEOUT_ERR  = r_timeout_err;
  assign bus.DROPPED      = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_network_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_scheduler
// Description : Self-checking bench: engine model, result scoreboard and a
//               directed scenario sequence for network_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_scheduler;
  import network_scheduler_pkg::*;

  localparam int FP = 8;
  localparam int HL = 10;
  localparam int OL = 5;

  typedef struct {
    int                 issue;
    int                 lat;
    logic [HL*FP-1:0]   hl;
    logic [OL*FP-1:0]   ol;
  } sb_t;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  network_scheduler_if #(.FP_WIDTH(FP), .HL_NEURONS(HL), .OL_NEURONS(OL)) bus ();

  network_scheduler #(
    .FP_WIDTH       (FP),
    .HL_NEURONS     (HL),
    .OL_NEURONS     (OL),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   vout_cnt = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  sb_t  drv_e;

  // Engine configuration, written by the main sequence only.
  logic [7:0] eng_base = 8'h00;
  int         ovf_hl   = -1;
  int         skip_l   = -1;
  int         skip_i   = -1;
  int         long_l   = -1;
  int         long_i   = -1;
  logic       spur     = 1'b0;

  // Engine model state.
  int   e_cnt   = 0;
  int   e_cur_l = 0;
  int   e_cur_i = 0;
  int   m_layer = 0;
  int   m_idx   = 0;
  logic e_prev_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine: answers each START after 3 cycles (255 for the configured slow
  // neuron, never for the skipped one) with RESULT = base + idx.
  initial begin
    bus.NEURON_DONE   = 1'b0;
    bus.NEURON_RESULT = '0;
    bus.NEURON_OVF    = 1'b0;
    forever begin
      @(negedge CLK);
      bus.NEURON_DONE   = spur;
      bus.NEURON_RESULT = spur ? 8'hAA : 8'h00;
      bus.NEURON_OVF    = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          if (bus.BUSY)
            check("idx_hold", {bus.NEURON_LAYER, bus.NEURON_IDX}, {1'(e_cur_l), 4'(e_cur_i)});
          bus.NEURON_DONE   = 1'b1;
          bus.NEURON_RESULT = eng_base + 8'(e_cur_i);
          bus.NEURON_OVF    = (e_cur_l == 0) && (e_cur_i == ovf_hl);
        end
      end
      if (bus.BUSY && !e_prev_busy) begin
        m_layer = 0;
        m_idx   = 0;
      end
      e_prev_busy = bus.BUSY;
      if (bus.NEURON_START) begin
        check("start_order", {bus.NEURON_LAYER, bus.NEURON_IDX}, {1'(m_layer), 4'(m_idx)});
        e_cur_l = m_layer;
        e_cur_i = m_idx;
        if (m_layer == 0 && m_idx == HL - 1) begin
          m_layer = 1;
          m_idx   = 0;
        end else begin
          m_idx++;
        end
        if (!(e_cur_l == skip_l && e_cur_i == skip_i))
          e_cnt = (e_cur_l == long_l && e_cur_i == long_i) ? 255 : 3;
      end
    end
  end

  // Output monitor: every VALID_OUT pops and checks one scoreboard entry.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.VALID_OUT) begin
        vout_cnt++;
        if (sb_q.size() == 0) begin
          check("vout_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("latency", 128'(cyc - mon_e.issue), 128'(mon_e.lat));
          check("hl_values", bus.HL_VALUES, mon_e.hl);
          check("values_out", bus.VALUES_OUT, mon_e.ol);
        end
      end
    end
  end

  task automatic send(input logic [7:0] base, input int lat, input bit push);
    @(negedge CLK);
    drv_e.issue = cyc;
    drv_e.lat   = lat;
    for (int i = 0; i < HL; i++) drv_e.hl[i*FP +: FP] = base + 8'(i);
    for (int i = 0; i < OL; i++) drv_e.ol[i*FP +: FP] = base + 8'(i);
    #1;
    bus.VALID_IN = 1'b1;
    if (push) sb_q.push_back(drv_e);
    @(negedge CLK);
    #1;
    bus.VALID_IN = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("done_in_budget", 1'(sb_q.size() == 0), 1'b1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_start(input int l, input int i, input int budget);
    int  n   = 0;
    bit  hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge CLK);
      n++;
      hit = bus.NEURON_START && (bus.NEURON_LAYER == 1'(l)) && (bus.NEURON_IDX == 4'(i));
    end
    check("start_seen", hit, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    #1 bus.CLR_FLAGS = 1'b1;
    @(negedge CLK);
    #1 bus.CLR_FLAGS = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.BUSY, 1'b0);
    check({tag, "_start"}, bus.NEURON_START, 1'b0);
    check({tag, "_vout"}, bus.VALID_OUT, 1'b0);
    check({tag, "_flags"}, {bus.OVERFLOW, bus.TIMEOUT_ERR, bus.DROPPED}, 3'b000);
    check({tag, "_hl"}, bus.HL_VALUES, '0);
    check({tag, "_ol"}, bus.VALUES_OUT, '0);
  endtask

  logic [OL*FP-1:0] ol_exp;
  logic [HL*FP-1:0] hl_exp;
  int               vout_before;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1);
  end

  initial begin
    bus.VALID_IN  = 1'b0;
    bus.CLR_FLAGS = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    #1 RSTN = 1'b1;

    // Spurious DONE while idle.
    @(negedge CLK);
    #1 spur = 1'b1;
    @(negedge CLK);
    #1 spur = 1'b0;
    repeat (2) @(negedge CLK);
    check("spur_busy", bus.BUSY, 1'b0);
    check("spur_hl", bus.HL_VALUES, '0);
    check("spur_ol", bus.VALUES_OUT, '0);

    // Nominal inference.
    eng_base = 8'h10;
    send(8'h10, 62, 1'b1);
    wait_done(200);
    check("hl9", bus.HL_VALUES[79:72], 8'h19);
    check("ol4", bus.VALUES_OUT[39:32], 8'h14);
    check("vout_count_nom", vout_cnt, 1);
    check("nom_flags", {bus.OVERFLOW, bus.TIMEOUT_ERR, bus.DROPPED}, 3'b000);

    // Overflow on hidden 3, output 1 answers exactly at the watchdog limit.
    eng_base = 8'h20;
    ovf_hl   = 3;
    long_l   = 1;
    long_i   = 1;
    send(8'h20, 62 + 252, 1'b1);
    wait_done(600);
    ovf_hl = -1;
    long_l = -1;
    long_i = -1;
    check("ovf_set", bus.OVERFLOW, 1'b1);
    check("limit_done_no_timeout", bus.TIMEOUT_ERR, 1'b0);
    pulse_clr();
    check("ovf_cleared", bus.OVERFLOW, 1'b0);

    // Request dropped while hidden neuron 5 is outstanding.
    eng_base    = 8'h30;
    vout_before = vout_cnt;
    send(8'h30, 62, 1'b1);
    wait_start(0, 5, 100);
    @(negedge CLK);
    #1 bus.VALID_IN = 1'b1;
    @(negedge CLK);
    #1 bus.VALID_IN = 1'b0;
    check("dropped_set", bus.DROPPED, 1'b1);
    check("drop_busy", bus.BUSY, 1'b1);
    wait_done(200);
    repeat (5) @(negedge CLK);
    check("vout_count_drop", vout_cnt, vout_before + 1);
    pulse_clr();
    check("dropped_cleared", bus.DROPPED, 1'b0);

    // Watchdog abort on output neuron 2.
    eng_base    = 8'h40;
    skip_l      = 1;
    skip_i      = 2;
    vout_before = vout_cnt;
    send(8'h40, 0, 1'b0);
    wait_start(1, 2, 200);
    repeat (255) @(negedge CLK);
    check("wd_busy_at_limit", bus.BUSY, 1'b1);
    check("wd_no_err_early", bus.TIMEOUT_ERR, 1'b0);
    @(negedge CLK);
    check("wd_idle", bus.BUSY, 1'b0);
    check("wd_err", bus.TIMEOUT_ERR, 1'b1);
    for (int i = 0; i < HL; i++) hl_exp[i*FP +: FP] = 8'h40 + 8'(i);
    for (int i = 0; i < OL; i++) ol_exp[i*FP +: FP] = (i < 2) ? 8'h40 + 8'(i) : 8'h30 + 8'(i);
    check("wd_hl", bus.HL_VALUES, hl_exp);
    check("wd_ol_partial", bus.VALUES_OUT, ol_exp);
    repeat (5) @(negedge CLK);
    check("wd_no_vout", vout_cnt, vout_before);
    skip_l = -1;
    skip_i = -1;

    // Reset pulse during the first output-layer START.
    eng_base = 8'h50;
    send(8'h50, 0, 1'b0);
    wait_start(1, 0, 200);
    #1 RSTN = 1'b0;
    @(negedge CLK);
    check_all_zero("midreset");
    #1 RSTN = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_reset_busy", bus.BUSY, 1'b0);
    check("post_reset_hl", bus.HL_VALUES, '0);
    check("post_reset_ol", bus.VALUES_OUT, '0);
    check("post_reset_no_vout", vout_cnt, vout_before);

    eng_base = 8'h60;
    send(8'h60, 62, 1'b1);
    wait_done(200);
    check("vout_count_final", vout_cnt, vout_before + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
